// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits answer one cycle after the lookup. A miss refills the whole line
// from its base address, one word per mem_req/mem_rdy handshake, and then
// returns the requested word.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_rdy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = 30 - OFF - IDX;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
  logic [OFF-1:0]       cnt;
  logic                 flush_pend;
  logic [29:0]          req_word;

  logic [OFF-1:0] lk_off;
  logic [IDX-1:0] lk_idx;
  logic [TAG-1:0] lk_tag;
  logic [OFF-1:0] rq_off;
  logic [IDX-1:0] rq_idx;
  logic [TAG-1:0] rq_tag;
  logic           lookup_hit;
  logic           unused_byte_bits;

  // Byte-select bits never matter for word fetches.
  assign unused_byte_bits = &{1'b0, icache_addr[1:0]};

  // Fields of the incoming fetch address and of the latched miss address.
  assign lk_off = icache_addr[2 +: OFF];
  assign lk_idx = icache_addr[2+OFF +: IDX];
  assign lk_tag = icache_addr[2+OFF+IDX +: TAG];
  assign rq_off = req_word[0 +: OFF];
  assign rq_idx = req_word[OFF +: IDX];
  assign rq_tag = req_word[OFF+IDX +: TAG];

  assign lookup_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  // Tag and data arrays: written only by refill beats, no reset needed.
  always_ff @(posedge clock) begin
    if (!reset && state == REFILL && mem_rdy) begin
      data_mem[{rq_idx, cnt}] <= mem_data;
      if (cnt == LAST_BEAT) begin
        tag_mem[rq_idx] <= rq_tag;
      end
    end
  end

  // Control FSM: lookup, line refill, response pulse, valid bits and flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      icache_rdy  <= 1'b0;
      icache_data <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      req_word    <= '0;
`ifdef ICACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      icache_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (icache_req && !icache_rdy) begin
            req_word <= icache_addr[31:2];
            if (lookup_hit) begin
              icache_rdy  <= 1'b1;
              icache_data <= data_mem[{lk_idx, lk_off}];
`ifdef ICACHE_STATS_EN
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
            end else begin
              state    <= REFILL;
              cnt      <= '0;
              mem_req  <= 1'b1;
              mem_addr <= {lk_tag, lk_idx, {OFF{1'b0}}, 2'b00};
`ifdef ICACHE_STATS_EN
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
            end
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (mem_rdy) begin
            cnt      <= cnt + OFF'(1);
            mem_addr <= mem_addr + 32'd4;
            if (cnt == LAST_BEAT) begin
              mem_req       <= 1'b0;
              valid[rq_idx] <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          icache_rdy  <= 1'b1;
          icache_data <= data_mem[{rq_idx, rq_off}];
          state       <= IDLE;
          if (flush || flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized self-checking bench for icache_dm against a
// line-level reference model (valid/tag per line, word-function memory).
module tb_icache_dm;

  localparam int LW    = 4;
  localparam int NL    = 64;
  localparam int OFFB  = $clog2(LW);
  localparam int IDXB  = $clog2(NL);

  logic        clock;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_rdy;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int waitStates  = 0;
  int waitCnt     = 0;
  logic [31:0] waitAddr = '0;
  logic [31:0] beatQ[$];

  bit refValid [NL];
  int refTag   [NL];
  int expHits   = 0;
  int expMisses = 0;

  icache_dm #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clock       (clock),
    .reset       (reset),
    .icache_addr (icache_addr),
    .icache_req  (icache_req),
    .icache_data (icache_data),
    .icache_rdy  (icache_rdy),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_data    (mem_data),
    .mem_rdy     (mem_rdy)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NL; i++) refValid[i] = 1'b0;
  endtask

  task automatic checkStats();
`ifdef ICACHE_STATS_EN
    checkOutput("hit_count", hit_count, expHits);
    checkOutput("miss_count", miss_count, expMisses);
`endif
  endtask

  // Memory responder: waitStates idle cycles, then one handshake per word.
  initial begin
    mem_rdy  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clock);
      mem_rdy = 1'b0;
      if (reset || !mem_req) begin
        waitCnt = 0;
      end else if (waitCnt < waitStates) begin
        if (waitCnt == 0) waitAddr = mem_addr;
        else checkOutput("mem_addr_stable", mem_addr, waitAddr);
        waitCnt++;
      end else begin
        if (waitStates > 0) checkOutput("mem_addr_stable", mem_addr, waitAddr);
        mem_rdy  = 1'b1;
        mem_data = memWord(mem_addr);
        beatQ.push_back(mem_addr);
        waitCnt  = 0;
      end
    end
  end

  // mode 0: plain fetch; 1: flush in the lookup cycle; 2: flush mid-refill.
  task automatic applyStimulus(input logic [31:0] addr, input int mode, input int waits);
    int lat, expLat, idx, tg;
    bit hit;
    logic [31:0] base;
    idx = int'((addr >> (2 + OFFB)) % NL);
    tg  = int'(addr >> (2 + OFFB + IDXB));
    base = (addr >> (2 + OFFB)) << (2 + OFFB);
    if (mode == 1) clearModel();
    hit = refValid[idx] && (refTag[idx] == tg);
    expLat = hit ? 1 : LW * (waits + 1) + 2;
    if (mode == 1) expLat++;
    if (hit) expHits++; else expMisses++;
    @(negedge clock);
    waitStates = waits;
    beatQ.delete();
    icache_addr = addr;
    icache_req  = 1'b1;
    flush       = (mode == 1);
    lat = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clock);
      #1;
      if (icache_rdy) begin
        lat = cyc;
        break;
      end
      @(negedge clock);
      flush = (mode == 2 && cyc == 2 && !hit);
    end
    flush = 1'b0;
    checkOutput("latency", lat, expLat);
    checkOutput("data", icache_data, memWord(addr));
    if (hit) begin
      checkOutput("hit_no_refill", beatQ.size(), 0);
    end else begin
      checkOutput("beat_count", beatQ.size(), LW);
      for (int i = 0; i < LW && i < beatQ.size(); i++)
        checkOutput("beat_addr", beatQ[i], base + 32'(4 * i));
      refValid[idx] = 1'b1;
      refTag[idx]   = tg;
      if (mode == 2) clearModel();
    end
    // Request still held across the edge ending the rdy cycle: no second pulse.
    @(posedge clock);
    #1;
    checkOutput("single_pulse", icache_rdy, 1'b0);
    checkOutput("data_hold", icache_data, memWord(addr));
    checkOutput("mem_req_idle", mem_req, 1'b0);
    checkStats();
    @(negedge clock);
    icache_req = 1'b0;
  endtask

  task automatic doFlush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    clearModel();
  endtask

  // Reset in the middle of a refill abandons it without installing the line.
  task automatic resetMidRefill();
    doFlush();
    @(negedge clock);
    waitStates  = 1;
    beatQ.delete();
    icache_addr = 32'h100;
    icache_req  = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clock);
      #1;
      if (beatQ.size() >= 2) break;
    end
    #1;
    reset      = 1'b1;
    icache_req = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_rdy", icache_rdy, 1'b0);
    checkOutput("rst_beats", beatQ.size(), 2);
    reset = 1'b0;
    clearModel();
    expHits   = 0;
    expMisses = 0;
    checkStats();
    applyStimulus(32'h100, 0, 0);
  endtask

  initial begin
    logic [31:0] a;
    int mode;
    reset = 1'b1;
    icache_addr = '0;
    icache_req  = 1'b0;
    flush       = 1'b0;
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_rdy", icache_rdy, 1'b0);
    checkOutput("reset_data", icache_data, 32'h0);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkStats();
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(32'h100, 0, 0);
    applyStimulus(32'h108, 0, 0);
    doFlush();
    applyStimulus(32'h100, 0, 0);
    applyStimulus(32'h500, 0, 0);
    applyStimulus(32'h100, 0, 0);
    doFlush();
    applyStimulus(32'h104, 0, 0);
`ifdef ICACHE_STATS_EN
    checkOutput("plan_hits", hit_count, 32'd1);
    checkOutput("plan_misses", miss_count, 32'd5);
`endif
    applyStimulus(32'h2000, 0, 3);
    for (int i = 1; i < LW; i++) applyStimulus(32'h2000 + 32'(4 * i), 0, 3);
    applyStimulus(32'h2008, 1, 0);
    applyStimulus(32'h3004, 2, 1);
    applyStimulus(32'h3004, 0, 0);
    resetMidRefill();

    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << (2 + OFFB + IDXB))
        | (32'($urandom_range(0, 3)) << (2 + OFFB))
        | (32'($urandom_range(0, LW - 1)) << 2)
        | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: mode = 1;
        1: mode = 2;
        default: mode = 0;
      endcase
      applyStimulus(a, mode, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction fetch port and the memory bus.
- Serves icache_addr/icache_req fetches from the core with a registered one-cycle hit latency.
- On a miss, refills one full line from memory over a single-outstanding word handshake, then returns the requested word.
- Provides a flush input for fence.i.

Parameters:
LINE_WORDS, 4, words per line; power of 2, >=2
NUM_LINES, 64, number of lines; power of 2, >=2

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
icache_addr  in  32  fetch byte address; bits [1:0] ignored
icache_req  in  1  fetch request; core holds it and icache_addr stable until icache_rdy
icache_data  out  32  fetched instruction; valid only while icache_rdy=1
icache_rdy  out  1  one-cycle completion pulse
flush  in  1  invalidate all lines
mem_addr  out  32  word-aligned refill address
mem_req  out  1  refill word request
mem_data  in  32  refill data; sampled when mem_rdy=1
mem_rdy  in  1  memory accepted mem_req and mem_data is valid this cycle

Behaviour:
- Address split: [1:0] byte; next OFF=log2(LINE_WORDS) bits word offset; next IDX=log2(NUM_LINES) bits index; rest tag.
- Storage: valid bit vector (flops), tag array, data array. Data/tag arrays need no reset.
- Reset values: state IDLE, all valid=0, icache_rdy=0, icache_data=0, mem_req=0, mem_addr=0, refill counter=0, pending flush=0.
- States: IDLE, REFILL, DONE.
- IDLE, lookup rule: a lookup occurs when icache_req=1 and icache_rdy=0 this cycle. In the cycle icache_rdy=1, icache_req is ignored, so a held request is never double-served. Maximum throughput is one hit per 2 cycles.
- Hit (valid[idx] && tag match): next cycle icache_rdy=1 and icache_data=word[off]; state stays IDLE.
- Miss: go to REFILL; counter=0; mem_req=1; mem_addr={tag,idx,OFF'b0,2'b00}. The refill always starts at the line base, whatever the requested offset.
- REFILL:
  - mem_req held high and mem_addr held stable until mem_rdy.
  - On mem_rdy: write mem_data to data[idx][counter]; counter++; mem_addr advances by 4 on the next cycle.
  - On the mem_rdy of beat LINE_WORDS-1: mem_req=0 next cycle; tag written; valid[idx]=1; go to DONE.
- DONE: icache_rdy=1 and icache_data=requested word for exactly one cycle; then IDLE.
- icache_data holds its last value when icache_rdy=0.
- Miss-to-rdy latency with zero wait states is LINE_WORDS+2 cycles.
- flush:
  - In IDLE: all valid bits cleared at the edge; flush has priority over a same-cycle lookup, which is deferred to the next cycle.
  - In REFILL/DONE: flush is latched as pending. The in-flight refill completes and responds normally. All valid bits are cleared on entry to IDLE, before any new lookup.
- Core contract: icache_req dropped or icache_addr changed before rdy is illegal. If icache_req drops mid-refill anyway, the refill completes and the DONE pulse is still issued.
- Reset mid-refill: abandons the refill; mem_req=0 after the edge; no line is installed.
- icache_req while in REFILL/DONE is not accepted for lookup.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - Each counter increments once per lookup classified as hit or miss respectively, and saturates at 0xFFFFFFFF.
  - Flush-deferred cycles are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset; req 0x100, zero-wait memory (LINE_WORDS=4) -> mem_addr sequence 0x100,0x104,0x108,0x10C; icache_rdy one cycle, 2 cycles after beat 3 handshake, with data from 0x100.
2. Then req 0x108 -> icache_rdy next cycle with word from 0x108, mem_req stays 0; holding req through the rdy cycle yields exactly one pulse.
3. Conflict (NUM_LINES=64): req 0x100, then 0x500, then 0x100 -> three misses, three refills.
4. flush, then req 0x104 -> miss and full refill from 0x100. With ICACHE_STATS_EN, after tests 1-4: hit_count=1, miss_count=5.
5. Memory with 3 wait cycles per beat -> mem_addr and mem_req stable during wait cycles; exactly 4 beats; line contents correct.
6. Reset asserted after 2 refill beats -> mem_req=0 the next cycle, icache_rdy=0; req 0x100 afterwards misses and refills starting at 0x100.
